// File: rtl/safe_seq_ctrl.sv
// Challenge/answer sequencer for the safe: loads four challenge digits, collects
// the keypad entry, checks it against the external calculator and drives unlock/alarm.
module safe_seq_ctrl #(
  parameter int MAX_TRIES   = 3,
  parameter int OPEN_CYCLES = 500,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  rnd_digit,
  input  logic        start,
  input  logic        admin_mode,
  input  logic        admin_op_we,
  input  logic [2:0]  admin_op,
  input  logic        key_valid,
  input  logic [3:0]  key_val,
  input  logic        key_clr,
  input  logic        key_enter,
  input  logic [15:0] correct_ans,
  output logic [3:0]  d1,
  output logic [3:0]  d2,
  output logic [3:0]  d3,
  output logic [3:0]  d4,
  output logic        op1,
  output logic        op2,
  output logic        op3,
  output logic [13:0] entry,
  output logic        unlock,
  output logic        alarm,
  output logic [1:0]  tries_left,
  output logic        busy,
  output logic [2:0]  state
);

  localparam int MAX_CNT = (LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ENTRY = 3'd2,
    CHECK = 3'd3,
    OPEN  = 3'd4,
    LOCK  = 3'd5
  } state_t;

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       key_cnt;
  logic [3:0]       fold_digit;

  // Random source produces 0..15; fold the non-decimal values back into 0..5.
  assign fold_digit = (rnd_digit > 4'd9) ? (rnd_digit - 4'd10) : rnd_digit;
  assign state      = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      cnt        <= '0;
      key_cnt    <= '0;
      d1         <= '0;
      d2         <= '0;
      d3         <= '0;
      d4         <= '0;
      op1        <= 1'b0;
      op2        <= 1'b0;
      op3        <= 1'b0;
      entry      <= '0;
      unlock     <= 1'b0;
      alarm      <= 1'b0;
      tries_left <= 2'(MAX_TRIES);
      busy       <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (admin_mode && admin_op_we) {op1, op2, op3} <= admin_op;
          if (start) begin
            st   <= LOAD;
            busy <= 1'b1;
            cnt  <= '0;
          end
        end
        LOAD: begin
          case (cnt[1:0])
            2'd0:    d1 <= fold_digit;
            2'd1:    d2 <= fold_digit;
            2'd2:    d3 <= fold_digit;
            default: d4 <= fold_digit;
          endcase
          if (cnt == CNT_W'(3)) begin
            st      <= ENTRY;
            cnt     <= '0;
            entry   <= '0;
            key_cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ENTRY: begin
          // Clear beats enter beats digit; the losers of a tie are dropped.
          if (key_clr) begin
            entry   <= '0;
            key_cnt <= '0;
          end else if (key_enter) begin
            if (key_cnt != 3'd0) st <= CHECK;
          end else if (key_valid && (key_cnt < 3'd4) && (key_val <= 4'd9)) begin
            entry   <= entry * 14'd10 + {10'd0, key_val};
            key_cnt <= key_cnt + 1'b1;
          end
        end
        CHECK: begin
          if ({2'b00, entry} == correct_ans) begin
            st     <= OPEN;
            unlock <= 1'b1;
            cnt    <= '0;
          end else if (tries_left > 2'd1) begin
            st         <= ENTRY;
            tries_left <= tries_left - 1'b1;
            entry      <= '0;
            key_cnt    <= '0;
          end else begin
            st         <= LOCK;
            tries_left <= 2'd0;
            alarm      <= 1'b1;
            cnt        <= '0;
          end
        end
        OPEN: begin
          if (cnt == CNT_W'(OPEN_CYCLES - 1)) begin
            st         <= IDLE;
            unlock     <= 1'b0;
            busy       <= 1'b0;
            tries_left <= 2'(MAX_TRIES);
            entry      <= '0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOCK: begin
          if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
            st         <= IDLE;
            alarm      <= 1'b0;
            busy       <= 1'b0;
            tries_left <= 2'(MAX_TRIES);
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          st   <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
